// File: rtl/stack_queue_buf.sv
// Run-time selectable LIFO/FIFO buffer with registered pop data, peek, occupancy
// status, sticky overflow/underflow flags and synchronous flush.
module stack_queue_buf #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 8,
  parameter  int AF_THRESH = DEPTH - 1,
  parameter  int AE_THRESH = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_vld_o,
  output logic [WIDTH-1:0] peek_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } mode_e;

  logic [WIDTH-1:0] mem_q [DEPTH];

  mode_e            mode_q, mode_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             is_empty, is_full;
  logic             pop_acc, push_acc;
  logic [PW-1:0]    top_idx, wr_idx;
  logic [WIDTH-1:0] rd_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  assign pop_acc  = pop_i & ~flush_i & ~is_empty;
  assign push_acc = push_i & ~flush_i & (~is_full | pop_acc);

  // Only meaningful when nonempty; wraps harmlessly at count 0.
  assign top_idx = PW'(count_q - CW'(1));

  always_comb begin
    wr_idx = wr_ptr_q;
    if (mode_q == MODE_LIFO) begin
      wr_idx = pop_acc ? top_idx : PW'(count_q);
    end
  end

  assign rd_data = (mode_q == MODE_FIFO) ? mem_q[rd_ptr_q] : mem_q[top_idx];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mode_d      = mode_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    overflow_d  = overflow_q & ~clr_err_i;
    underflow_d = underflow_q & ~clr_err_i;

    if (pop_acc) begin
      dout_d     = rd_data;
      dout_vld_d = 1'b1;
    end

    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (mode_q == MODE_FIFO) begin
        if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
      end
    end

    // Mode switches only on an idle, empty edge; a request while occupied waits here.
    if ((is_empty && !push_i) || flush_i) begin
      mode_d = mode_e'(mode_i);
      if (mode_d != mode_q) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end
    end

    if (push_i && !push_acc && !flush_i) overflow_d  = 1'b1;
    if (pop_i && !pop_acc && !flush_i)   underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q      <= mode_e'(mode_i);
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push_acc) mem_q[wr_idx] <= din_i;
  end

  assign dout_o         = dout_q;
  assign dout_vld_o     = dout_vld_q;
  assign peek_o         = is_empty ? '0 : rd_data;
  assign count_o        = count_q;
  assign empty_o        = is_empty;
  assign full_o         = is_full;
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_stack_queue_buf.sv
// Directed bench for stack_queue_buf: expected pop data is queued at issue time
// and checked by a monitor on each dout_vld pulse; status is checked inline.
module tb_stack_queue_buf;

  logic       clk = 1'b0;
  logic       rstn;
  logic       mode_i, push_i, pop_i, flush_i, clr_err_i;
  logic [7:0] din_i;
  logic [7:0] dout_o, peek_o;
  logic       dout_vld_o;
  logic [3:0] count_o;
  logic       empty_o, full_o, almost_empty_o, almost_full_o, overflow_o, underflow_o;

  int applied = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  stack_queue_buf #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .mode_i(mode_i), .push_i(push_i), .din_i(din_i),
    .pop_i(pop_i), .flush_i(flush_i), .clr_err_i(clr_err_i), .dout_o(dout_o),
    .dout_vld_o(dout_vld_o), .peek_o(peek_o), .count_o(count_o), .empty_o(empty_o),
    .full_o(full_o), .almost_empty_o(almost_empty_o), .almost_full_o(almost_full_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; pop_ok queues the value the pop must return.
  task automatic op(input logic ps, input logic [7:0] d, input logic pp, input logic fl,
                    input logic pop_ok, input logic [7:0] pv, input int exp_cnt);
    push_i = ps; din_i = d; pop_i = pp; flush_i = fl;
    if (pop_ok) sb.push_back(pv);
    @(posedge clk); #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
    chk("count", 32'(count_o), 32'(exp_cnt));
  endtask

  task automatic psh(input logic [7:0] d, input int c);
    op(1'b1, d, 1'b0, 1'b0, 1'b0, 8'h00, c);
  endtask

  task automatic pp(input logic [7:0] v, input int c);
    op(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, v, c);
  endtask

  task automatic idle(input int c);
    op(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, c);
  endtask

  task automatic clr();
    clr_err_i = 1'b1;
    @(posedge clk); #1;
    clr_err_i = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (dout_vld_o) begin
        if (sb.size() == 0) chk("unexpected_vld_dout", 32'(dout_o), 32'hFFFF_FFFF);
        else chk("dout", 32'(dout_o), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    rstn = 1'b0; mode_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
    clr_err_i = 1'b0; din_i = 8'h00;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_ae", 32'(almost_empty_o), 1);
    chk("rst_af", 32'(almost_full_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_udf", 32'(underflow_o), 0);
    chk("rst_dout", 32'(dout_o), 0);
    chk("rst_peek", 32'(peek_o), 0);

    // Empty handling (LIFO)
    op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    chk("udf_set", 32'(underflow_o), 1);
    chk("udf_dout_hold", 32'(dout_o), 0);
    op(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1);
    chk("pushpop_empty_peek", 32'(peek_o), 32'h5A);
    clr();
    chk("udf_clr", 32'(underflow_o), 0);
    pp(8'h5A, 0);

    // LIFO order
    psh(8'h11, 1); psh(8'h22, 2); psh(8'h33, 3);
    chk("lifo_peek", 32'(peek_o), 32'h33);
    pp(8'h33, 2); pp(8'h22, 1); pp(8'h11, 0);
    chk("lifo_empty", 32'(empty_o), 1);

    // Fill, thresholds, overflow, push+pop when full
    for (int i = 1; i <= 8; i++) begin
      psh(8'(i), i);
      if (i == 1) chk("ae_at_1", 32'(almost_empty_o), 1);
      if (i == 2) chk("ae_at_2", 32'(almost_empty_o), 0);
      if (i == 6) chk("af_at_6", 32'(almost_full_o), 0);
      if (i == 7) begin
        chk("af_at_7", 32'(almost_full_o), 1);
        chk("full_at_7", 32'(full_o), 0);
      end
    end
    chk("full_at_8", 32'(full_o), 1);
    psh(8'h09, 8);
    chk("ovf_set", 32'(overflow_o), 1);
    clr();
    chk("ovf_clr", 32'(overflow_o), 0);
    op(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h08, 8);
    chk("full_pushpop_ovf", 32'(overflow_o), 0);
    chk("full_pushpop_peek", 32'(peek_o), 32'h99);
    pp(8'h99, 7);
    for (int i = 7; i >= 1; i--) pp(8'(i), i - 1);

    // Deferred mode change
    psh(8'hC1, 1); psh(8'hC2, 2);
    mode_i = 1'b1;
    idle(2);
    chk("mode_deferred_peek", 32'(peek_o), 32'hC2);
    psh(8'hC3, 3);
    pp(8'hC3, 2); pp(8'hC2, 1); pp(8'hC1, 0);
    idle(0);

    // FIFO with pointer wrap
    psh(8'hA0, 1);
    chk("fifo_peek", 32'(peek_o), 32'hA0);
    psh(8'hA1, 2); psh(8'hA2, 3); psh(8'hA3, 4);
    pp(8'hA0, 3);
    psh(8'hA4, 4); psh(8'hA5, 5); psh(8'hA6, 6); psh(8'hA7, 7);
    pp(8'hA1, 6);
    psh(8'hA8, 7); psh(8'hA9, 8);
    chk("fifo_full", 32'(full_o), 1);
    op(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'hA2, 8);
    chk("fifo_peek_wrap", 32'(peek_o), 32'hA3);
    for (int i = 3; i <= 9; i++) pp(8'hA0 + 8'(i), 10 - i);
    chk("fifo_peek_last", 32'(peek_o), 32'hAA);
    pp(8'hAA, 0);

    // Flush with coincident push
    for (int i = 0; i < 5; i++) psh(8'h31 + 8'(i), i + 1);
    op(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 0);
    chk("flush_empty", 32'(empty_o), 1);
    chk("flush_peek", 32'(peek_o), 0);
    chk("flush_ovf", 32'(overflow_o), 0);
    psh(8'h44, 1);
    chk("post_flush_peek", 32'(peek_o), 32'h44);
    pp(8'h44, 0);

    // Mid-stream reset
    psh(8'h55, 1); pp(8'h55, 0);
    op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    chk("udf_before_rst", 32'(underflow_o), 1);
    psh(8'h66, 1); psh(8'h67, 2);
    mode_i = 1'b0; rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_empty", 32'(empty_o), 1);
    chk("mid_rst_dout", 32'(dout_o), 0);
    chk("mid_rst_vld", 32'(dout_vld_o), 0);
    chk("mid_rst_udf", 32'(underflow_o), 0);
    chk("mid_rst_ovf", 32'(overflow_o), 0);
    chk("mid_rst_peek", 32'(peek_o), 0);
    psh(8'h01, 1); psh(8'h02, 2);
    pp(8'h02, 1); pp(8'h01, 0);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
